// File: rtl/irq_vector_sequencer.sv
// rtl/irq_vector_sequencer.sv - single-level interrupt sequencer driving the PC redirect inputs
module irq_vector_sequencer #(
   parameter int unsigned NUM_IRQ       = 4,
   parameter logic [31:0] VECTOR_BASE   = 32'h0000_0100,
   parameter int unsigned VECTOR_STRIDE = 16,
   localparam int unsigned ID_W         = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [NUM_IRQ-1:0] irq_req,
   input  logic               mask_wr,
   input  logic [NUM_IRQ-1:0] mask_wdata,
   input  logic               global_en,
   input  logic [31:0]        pc,
   input  logic               instr_valid,
   input  logic               core_redirect,
   input  logic               mret,
   output logic               pc_jump,
   output logic [31:0]        pc_target,
   output logic [NUM_IRQ-1:0] irq_ack,
   output logic               in_handler,
   output logic [ID_W-1:0]    active_id,
   output logic [31:0]        epc
);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      TAKE    = 2'd1,
      HANDLER = 2'd2,
      RETURN  = 2'd3
   } state_t;

   state_t             state;
   state_t             state_next;
   logic [NUM_IRQ-1:0] req_prev;
   logic [NUM_IRQ-1:0] pending;
   logic [NUM_IRQ-1:0] mask;
   logic [NUM_IRQ-1:0] eligible;
   logic [NUM_IRQ-1:0] ack_onehot;
   logic [ID_W-1:0]    win_id;
   logic [31:0]        vector_addr;
   logic               take_ok;
   logic               take;

   assign eligible    = pending & ~mask;
   assign ack_onehot  = NUM_IRQ'(1) << active_id;
   assign vector_addr = VECTOR_BASE + 32'(active_id) * VECTOR_STRIDE;

   // Entry is only allowed on a clean retirement boundary so epc = pc + 4 is a valid resume point.
   assign take_ok = global_en & (|eligible) & instr_valid & ~core_redirect & ~mret;

   // Lowest-index eligible source wins; scanning downward leaves the smallest index last.
   always_comb begin
      win_id = '0;
      for (int i = NUM_IRQ - 1; i >= 0; i--) begin
         if (eligible[i]) begin
            win_id = ID_W'(i);
         end
      end
   end

   // State register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next-state and redirect/ack outputs; jump and ack only exist in the one-cycle TAKE/RETURN states.
   always_comb begin
      state_next = state;
      pc_jump    = 1'b0;
      pc_target  = '0;
      irq_ack    = '0;
      in_handler = 1'b0;
      take       = 1'b0;
      case (state)
         IDLE: begin
            if (take_ok) begin
               take       = 1'b1;
               state_next = TAKE;
            end
         end
         TAKE: begin
            pc_jump    = 1'b1;
            pc_target  = vector_addr;
            irq_ack    = ack_onehot;
            state_next = HANDLER;
         end
         HANDLER: begin
            in_handler = 1'b1;
            if (mret && instr_valid) begin
               state_next = RETURN;
            end
         end
         RETURN: begin
            pc_jump    = 1'b1;
            pc_target  = epc;
            in_handler = 1'b1;
            state_next = IDLE;
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // Edge capture, pending bookkeeping and mask; a fresh edge wins over the TAKE clear of the same bit.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         req_prev <= '0;
         pending  <= '0;
         mask     <= '1;
      end else begin
         req_prev <= irq_req;
         pending  <= (pending & ~irq_ack) | (irq_req & ~req_prev);
         if (mask_wr) begin
            mask <= mask_wdata;
         end
      end
   end

   // Service context is captured at the entry decision and held until the next entry.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         active_id <= '0;
         epc       <= '0;
      end else if (take) begin
         active_id <= win_id;
         epc       <= pc + 32'd4;
      end
   end

endmodule
